// File: rtl/sdram_cnt.sv
// Single-word SDRAM controller: power-up init, then read/write with auto-precharge.
// Periodic auto-refresh is compiled in only when SDRAM_AUTO_REFRESH_EN is defined.
module sdram_cnt #(
   parameter int unsigned INIT_WAIT        = 2000,
   parameter int unsigned REFRESH_INTERVAL = 1500,
   parameter int unsigned CAS_LATENCY      = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        we,
   input  logic [11:0] addr_in,
   input  logic [31:0] data_in,
   output logic        rdy,
   output logic [31:0] data_out,
   output logic        valid,
   output logic [31:0] Dq_out,
   output logic [31:0] Dq_oe,
   input  logic [31:0] Dq_in,
   output logic [10:0] Addr,
   output logic [1:0]  Ba,
   output logic        Cke,
   output logic        Cs_n,
   output logic        Ras_n,
   output logic        Cas_n,
   output logic        We_n,
   output logic [3:0]  Dqm
);

   localparam int unsigned CntW    = $clog2((INIT_WAIT > REFRESH_INTERVAL) ? INIT_WAIT : REFRESH_INTERVAL);
   localparam int unsigned DataW   = 32;
   localparam int unsigned SdAddrW = 11;

   localparam logic [2:0] S_INIT     = 3'd0;
   localparam logic [2:0] S_IDLE     = 3'd1;
   localparam logic [2:0] S_REFRESH  = 3'd2;
   localparam logic [2:0] S_ACTIVATE = 3'd3;
   localparam logic [2:0] S_READ     = 3'd4;
   localparam logic [2:0] S_WRITE    = 3'd5;
   localparam logic [2:0] S_WAIT     = 3'd6;

   // {Cs_n, Ras_n, Cas_n, We_n}
   localparam logic [3:0] CMD_DESEL = 4'b1111;
   localparam logic [3:0] CMD_NOP   = 4'b0111;
   localparam logic [3:0] CMD_ACT   = 4'b0011;
   localparam logic [3:0] CMD_RD    = 4'b0101;
   localparam logic [3:0] CMD_WR    = 4'b0100;
   localparam logic [3:0] CMD_PRE   = 4'b0010;
   localparam logic [3:0] CMD_REF   = 4'b0001;
   localparam logic [3:0] CMD_MRS   = 4'b0000;

   localparam logic [SdAddrW-1:0] ModeReg = SdAddrW'(CAS_LATENCY * 16);

   logic [2:0]         state_q, state_d, ret_q, ret_d;
   logic [CntW-1:0]    tmr_q, tmr_d;
   logic [1:0]         step_q, step_d;
   logic               rd_q, rd_d, init_done_q, init_done_d;
   logic               req_we_q, req_we_d;
   logic [11:0]        req_addr_q, req_addr_d;
   logic [DataW-1:0]   req_data_q, req_data_d;
   logic [3:0]         cmd_q, cmd_d, dqm_q, dqm_d;
   logic [SdAddrW-1:0] addr_q, addr_d;
   logic [1:0]         ba_q, ba_d;
   logic               cke_q, cke_d, rdy_q, rdy_d, valid_q, valid_d;
   logic [DataW-1:0]   dq_out_q, dq_out_d, dq_oe_q, dq_oe_d, data_q, data_d;
   logic               ref_pend_c, ref_block_c;
   logic [SdAddrW-1:0] row_c, col_c;

   assign row_c = {9'b0, req_addr_q[11:10]};
   assign col_c = {3'b100, req_addr_q[7:0]};

`ifdef SDRAM_AUTO_REFRESH_EN
   logic [CntW-1:0] ref_cnt_q, ref_cnt_d;
   logic            ref_pend_q, ref_pend_d, ref_due_c;

   // Free-running refresh interval timer; pending flag clears when REFRESH is issued.
   always_comb begin
      ref_due_c  = init_done_q && (ref_cnt_q == CntW'(REFRESH_INTERVAL - 1));
      ref_cnt_d  = (!init_done_q || ref_due_c) ? '0 : ref_cnt_q + CntW'(1);
      ref_pend_d = (ref_pend_q && (state_q != S_REFRESH)) || ref_due_c;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ref_cnt_q  <= '0;
         ref_pend_q <= 1'b0;
      end else begin
         ref_cnt_q  <= ref_cnt_d;
         ref_pend_q <= ref_pend_d;
      end
   end

   assign ref_pend_c  = ref_pend_q;
   assign ref_block_c = ref_pend_d;
`else
   assign ref_pend_c  = 1'b0;
   assign ref_block_c = 1'b0;
`endif

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      ret_d       = ret_q;
      tmr_d       = tmr_q;
      step_d      = step_q;
      rd_d        = rd_q;
      init_done_d = init_done_q;
      req_we_d    = req_we_q;
      req_addr_d  = req_addr_q;
      req_data_d  = req_data_q;
      cmd_d       = CMD_NOP;
      addr_d      = '0;
      ba_d        = '0;
      cke_d       = 1'b1;
      dq_out_d    = '0;
      dq_oe_d     = '0;
      valid_d     = 1'b0;
      data_d      = data_q;

      case (state_q)
         S_INIT: begin
            if (tmr_q != '0) begin
               tmr_d = tmr_q - CntW'(1);
            end else begin
               state_d = S_WAIT;
               step_d  = step_q + 2'd1;
               ret_d   = S_INIT;
               case (step_q)
                  2'd0: begin
                     cmd_d  = CMD_PRE;
                     addr_d = 11'h400;
                     tmr_d  = CntW'(1);
                  end
                  2'd3: begin
                     cmd_d  = CMD_MRS;
                     addr_d = ModeReg;
                     tmr_d  = CntW'(1);
                     step_d = step_q;
                     ret_d  = S_IDLE;
                  end
                  default: begin
                     cmd_d = CMD_REF;
                     tmr_d = CntW'(6);
                  end
               endcase
            end
         end
         S_IDLE: begin
            if (ref_pend_c) begin
               state_d = S_REFRESH;
            end else if (en) begin
               req_we_d   = we;
               req_addr_d = addr_in;
               req_data_d = data_in;
               state_d    = S_ACTIVATE;
            end
         end
         S_REFRESH: begin
            cmd_d   = CMD_REF;
            tmr_d   = CntW'(6);
            ret_d   = S_IDLE;
            state_d = S_WAIT;
         end
         S_ACTIVATE: begin
            cmd_d   = CMD_ACT;
            addr_d  = row_c;
            ba_d    = req_addr_q[9:8];
            tmr_d   = CntW'(1);
            ret_d   = req_we_q ? S_WRITE : S_READ;
            state_d = S_WAIT;
         end
         S_WRITE: begin
            cmd_d    = CMD_WR;
            addr_d   = col_c;
            ba_d     = req_addr_q[9:8];
            dq_oe_d  = '1;
            dq_out_d = req_data_q;
            tmr_d    = CntW'(3);
            ret_d    = S_IDLE;
            state_d  = S_WAIT;
         end
         S_READ: begin
            cmd_d   = CMD_RD;
            addr_d  = col_c;
            ba_d    = req_addr_q[9:8];
            tmr_d   = CntW'(CAS_LATENCY);
            rd_d    = 1'b1;
            ret_d   = S_IDLE;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A pending read captures DQ, then holds one more cycle so valid precedes IDLE.
            if (tmr_q != '0) begin
               tmr_d = tmr_q - CntW'(1);
            end else if (rd_q) begin
               data_d  = Dq_in;
               valid_d = 1'b1;
               rd_d    = 1'b0;
            end else begin
               state_d = ret_q;
               if (ret_q == S_IDLE) init_done_d = 1'b1;
            end
         end
         default: state_d = S_INIT;
      endcase

      dqm_d = init_done_d ? 4'h0 : 4'hF;
      rdy_d = (state_d == S_IDLE) && !ref_block_c;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_INIT;
         ret_q       <= S_INIT;
         tmr_q       <= CntW'(INIT_WAIT - 1);
         step_q      <= '0;
         rd_q        <= 1'b0;
         init_done_q <= 1'b0;
         req_we_q    <= 1'b0;
         req_addr_q  <= '0;
         req_data_q  <= '0;
         cmd_q       <= CMD_DESEL;
         addr_q      <= '0;
         ba_q        <= '0;
         cke_q       <= 1'b0;
         dqm_q       <= 4'hF;
         dq_out_q    <= '0;
         dq_oe_q     <= '0;
         data_q      <= '0;
         rdy_q       <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         ret_q       <= ret_d;
         tmr_q       <= tmr_d;
         step_q      <= step_d;
         rd_q        <= rd_d;
         init_done_q <= init_done_d;
         req_we_q    <= req_we_d;
         req_addr_q  <= req_addr_d;
         req_data_q  <= req_data_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
         ba_q        <= ba_d;
         cke_q       <= cke_d;
         dqm_q       <= dqm_d;
         dq_out_q    <= dq_out_d;
         dq_oe_q     <= dq_oe_d;
         data_q      <= data_d;
         rdy_q       <= rdy_d;
         valid_q     <= valid_d;
      end
   end

   assign {Cs_n, Ras_n, Cas_n, We_n} = cmd_q;
   assign Addr     = addr_q;
   assign Ba       = ba_q;
   assign Cke      = cke_q;
   assign Dqm      = dqm_q;
   assign Dq_out   = dq_out_q;
   assign Dq_oe    = dq_oe_q;
   assign data_out = data_q;
   assign rdy      = rdy_q;
   assign valid    = valid_q;

endmodule

// File: tb/tb_sdram_cnt.sv
// Directed bench for sdram_cnt with a behavioural SDRAM on the inverted clock.
module tb_sdram_cnt;

   localparam int unsigned CL = 2;
   localparam logic [3:0] C_NOP = 4'b0111;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam logic [3:0] C_WR  = 4'b0100;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_REF = 4'b0001;
   localparam logic [3:0] C_MRS = 4'b0000;
   localparam logic [31:0] POISON = 32'h0BAD_F00D;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0, we = 1'b0;
   logic [11:0] addr_in = '0;
   logic [31:0] data_in = '0;
   logic        rdy, valid, Cke, Cs_n, Ras_n, Cas_n, We_n;
   logic [31:0] data_out, Dq_out, Dq_oe;
   logic [31:0] Dq_in = POISON;
   logic [10:0] Addr;
   logic [1:0]  Ba;
   logic [3:0]  Dqm;

   sdram_cnt dut (
      .clk(clk), .rst(rst), .en(en), .we(we), .addr_in(addr_in), .data_in(data_in),
      .rdy(rdy), .data_out(data_out), .valid(valid), .Dq_out(Dq_out), .Dq_oe(Dq_oe),
      .Dq_in(Dq_in), .Addr(Addr), .Ba(Ba), .Cke(Cke), .Cs_n(Cs_n), .Ras_n(Ras_n),
      .Cas_n(Cas_n), .We_n(We_n), .Dqm(Dqm)
   );

   always #5 clk = ~clk;

   int unsigned n_chk = 0, n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Behavioural SDRAM plus protocol monitor, clocked on the falling edge.
   logic [31:0] mem [logic [20:0]];
   logic [10:0] row_r [4];
   logic [31:0] rd_val = POISON;
   int unsigned rd_cnt = 0, ref_n = 0, proto_err = 0, valid_n = 0, log_n = 0;
   logic [3:0]  log_cmd [4];
   logic [10:0] log_addr [4];
   logic [3:0]  log_dqm [4];
   logic        mark = 1'b0, mark_seen = 1'b0;
   logic [3:0]  first_cmd = C_NOP;
   wire  [3:0]  cmd = {Cs_n, Ras_n, Cas_n, We_n};

   always @(negedge clk) begin
      Dq_in = POISON;
      if (rd_cnt != 0) begin
         rd_cnt--;
         if (rd_cnt == 0) Dq_in = rd_val;
      end
      if (!mark) mark_seen = 1'b0;
      if (!rst) begin
         log_n = 0;
      end else if (Cke && !Cs_n && cmd != C_NOP) begin
         if (log_n < 4) begin
            log_cmd[log_n] = cmd; log_addr[log_n] = Addr; log_dqm[log_n] = Dqm; log_n++;
         end
         if (mark && !mark_seen) begin first_cmd = cmd; mark_seen = 1'b1; end
         case (cmd)
            C_ACT: row_r[Ba] = Addr;
            C_WR: begin
               mem[{Ba, row_r[Ba], Addr[7:0]}] = Dq_out;
               if (Dq_oe != '1 || Dqm != 4'h0 || !Addr[10]) proto_err++;
            end
            C_RD: begin
               rd_val = mem.exists({Ba, row_r[Ba], Addr[7:0]}) ? mem[{Ba, row_r[Ba], Addr[7:0]}] : POISON;
               rd_cnt = CL;
               if (!Addr[10]) proto_err++;
            end
            C_REF: begin
               ref_n++;
               if (rdy) proto_err++;
            end
            default: ;
         endcase
      end
      if (rst && cmd != C_WR && Dq_oe != '0) proto_err++;
      if (valid) valid_n++;
   end

   logic [31:0] exp_mem [logic [11:0]];
   int unsigned reads_done = 0;

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wait_rdy(input string tag);
      int n = 0;
      while (!rdy && n < 200) begin step(); n++; end
      if (!rdy) check({tag, "_rdy_timeout"}, 32'(rdy), 32'd1);
   endtask

   task automatic issue(input logic w, input logic [11:0] a, input logic [31:0] d, input string tag);
      wait_rdy(tag);
      en = 1'b1; we = w; addr_in = a; data_in = d;
      step();
      en = 1'b0;
      check({tag, "_busy"}, 32'(rdy), 32'd0);
   endtask

   task automatic do_write(input logic [11:0] a, input logic [31:0] d, input string tag);
      issue(1'b1, a, d, tag);
      exp_mem[a] = d;
   endtask

   task automatic do_read(input logic [11:0] a, input logic [31:0] exp, input string tag);
      int n = 0;
      issue(1'b0, a, '0, tag);
      while (!valid && n < 30) begin step(); n++; end
      check({tag, "_valid"}, 32'(valid), 32'd1);
      check({tag, "_data"}, data_out, exp);
      step();
      check({tag, "_pulse"}, 32'(valid), 32'd0);
      reads_done++;
   endtask

   task automatic gap();
      repeat ($urandom_range(9)) step();
   endtask

   task automatic init_checks(input string tag);
      int n = 0;
      while (!rdy && n < 2100) begin step(); n++; end
      check({tag, "_rdy_lt2100"}, 32'(rdy), 32'd1);
      check({tag, "_cmd0_pre"}, 32'(log_cmd[0]), 32'(C_PRE));
      check({tag, "_pre_a10"}, 32'(log_addr[0][10]), 32'd1);
      check({tag, "_cmd1_ref"}, 32'(log_cmd[1]), 32'(C_REF));
      check({tag, "_cmd2_ref"}, 32'(log_cmd[2]), 32'(C_REF));
      check({tag, "_cmd3_mrs"}, 32'(log_cmd[3]), 32'(C_MRS));
      check({tag, "_mode"}, 32'(log_addr[3]), 32'h020);
      check({tag, "_dqm_init"}, 32'(log_dqm[3]), 32'hF);
      check({tag, "_dqm_idle"}, 32'(Dqm), 32'h0);
   endtask

   initial begin
      int unsigned ref0;
      int n;
      repeat (3) step();
      check("rst_cke", 32'(Cke), 32'd0);
      check("rst_cmd", 32'(cmd), 32'hF);
      check("rst_addr_ba", 32'({Addr, Ba}), 32'd0);
      check("rst_dqm", 32'(Dqm), 32'hF);
      check("rst_dq_oe", Dq_oe, 32'd0);
      check("rst_dq_out", Dq_out, 32'd0);
      check("rst_rdy_valid", 32'({rdy, valid}), 32'd0);
      check("rst_data_out", data_out, 32'd0);
      rst = 1'b1;
      init_checks("init");

      do_write(12'h123, 32'hDEADBEEF, "w123");
      do_read(12'h123, 32'hDEADBEEF, "r123");
      wait_rdy("r123_back");
      check("r123_rdy_back", 32'(rdy), 32'd1);

      do_write(12'h000, 32'h11111111, "w000");
      do_write(12'hFFE, 32'h22222222, "wFFE");
      do_read(12'h000, 32'h11111111, "r000");
      do_read(12'hFFE, 32'h22222222, "rFFE");
      do_read(12'h123, 32'hDEADBEEF, "r123_again");

      // en held while busy must be dropped, not queued
      do_write(12'h055, 32'hA5A5A5A5, "w055");
      do_write(12'h0AA, 32'h12345678, "w0AA");
      en = 1'b1; we = 1'b1; addr_in = 12'h055; data_in = 32'hBADBAD00;
      repeat (3) step();
      en = 1'b0;
      do_read(12'h055, 32'hA5A5A5A5, "ignored_en");
      do_read(12'h0AA, 32'h12345678, "r0AA");

      for (int it = 0; it < 256; it++) begin
         logic [11:0] a1, a2;
         logic [31:0] d1, d2;
         a1 = 12'($urandom_range(4095));
         a2 = a1 ^ 12'($urandom_range(4095, 1));
         d1 = $urandom();
         d2 = $urandom();
         do_write(a1, d1, "rnd_w1"); gap();
         do_write(a2, d2, "rnd_w2"); gap();
         do_read(a1, d1, "rnd_r1"); gap();
         do_read(a2, d2, "rnd_r2"); gap();
      end

      ref0 = ref_n;
      repeat (5000) step();
`ifdef SDRAM_AUTO_REFRESH_EN
      check("idle_refresh_ge3", 32'(ref_n - ref0 >= 3), 32'd1);
      n = 0;
      while (rdy && n < 2000) begin step(); n++; end
      check("refresh_due_seen", 32'(rdy), 32'd0);
      mark = 1'b1;
      en = 1'b1; we = 1'b1; addr_in = 12'h3C3; data_in = 32'hC0FFEE00;
      n = 0;
      while (!rdy && n < 50) begin step(); n++; end
      step();
      en = 1'b0;
      exp_mem[12'h3C3] = 32'hC0FFEE00;
      check("refresh_before_req", 32'(first_cmd), 32'(C_REF));
      mark = 1'b0;
      do_read(12'h3C3, 32'hC0FFEE00, "r3C3");
`else
      check("no_periodic_refresh", ref_n - ref0, 32'd0);
`endif

      // reset in the middle of an access, then full re-init
      issue(1'b0, 12'h123, '0, "abort");
      repeat (2) step();
      rst = 1'b0;
      #1;
      check("abort_cke", 32'(Cke), 32'd0);
      check("abort_cmd", 32'(cmd), 32'hF);
      check("abort_rdy_valid_dqm", 32'({rdy, valid, Dqm}), 32'hF);
      repeat (3) step();
      rst = 1'b1;
      init_checks("reinit");
      do_read(12'h123, exp_mem[12'h123], "r123_post_reset");

      step();
      check("protocol_errs", proto_err, 32'd0);
      check("valid_pulse_count", valid_n, reads_done);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
